sys_bus_arbiter: RTL and testbench
==================================

# sys_bus_arbiter

Two-master, multi-slave system-bus controller placed between the memory-side ports of the LSU (master 0) and a second bus master such as a DMA or boot loader (master 1), and the data memory and peripheral controllers. It arbitrates the masters round-robin, decodes `addr[31:24]` into a one-hot slave request, and forwards a 24-bit local address. It waits for the slave's ready, muxes read data back, and flags unmapped or timed-out accesses as errors. This replaces ad-hoc address decode and read-data muxing in the processor system top.

## Interface
- `SLV_NUM`, 8: number of slave slots; slot k is selected when `addr[31:24] == k`.
- `TIMEOUT`, 15: maximum cycles in ACCESS waiting for slave ready before an error response.
- `clk_i` in 1: system clock.
- `resetn_i` in 1: reset, asynchronous, active-low.
- `m_req_i` in 2: per-master request, held until that master's `m_ready_o`.
- `m_we_i` in 2: per-master write enable.
- `m_be_i` in 2×4: per-master byte enables.
- `m_addr_i` in 2×32: per-master byte address.
- `m_wd_i` in 2×32: per-master write data.
- `m_rd_o` out 32: read data, valid while `m_ready_o` of the granted master is high.
- `m_ready_o` out 2: one-cycle completion pulse per master.
- `m_err_o` out 1: qualifies `m_ready_o`; 1 means unmapped slot or timeout.
- `s_req_o` out SLV_NUM: one-hot slave request.
- `s_we_o` out 1: latched write enable.
- `s_be_o` out 4: latched byte enables.
- `s_addr_o` out 32: `{8'd0, addr[23:0]}`.
- `s_wd_o` out 32: latched write data.
- `s_rd_i` in SLV_NUM×32: per-slave read data.
- `s_ready_i` in SLV_NUM: per-slave ready; may be high in the first ACCESS cycle.

## Operation
- FSM states are IDLE, ACCESS and RESP.
  - IDLE: if any `m_req_i` is set, grant one master and latch its we/be/addr/wd into command registers; go to ACCESS.
  - ACCESS: drive `s_req_o[slot]` every cycle.
    - On `s_ready_i[slot]`: capture `s_rd_i[slot]` (reads only; writes capture 0) and go to RESP with err=0.
    - If `slot >= SLV_NUM`: no `s_req_o` is driven; go to RESP with err=1 and rd=0.
    - If the timeout counter reaches TIMEOUT: go to RESP with err=1 and rd=0.
  - RESP: pulse `m_ready_o[grant]` with `m_rd_o` and `m_err_o`; go to IDLE.
- Arbitration is round-robin via a `last` pointer.
  - When both masters request, grant `~last`.
  - When one master requests, grant it.
  - `last` updates on each grant.
  - Reset value `last=1`, so master 0 wins the first tie.
- Command registers are frozen from grant until RESP; master input changes mid-transaction are ignored.
- A master that keeps `m_req_i` high through RESP is treated as issuing a new request and is re-arbitrated in the following IDLE cycle. Under contention the other master is served first.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide, cleared on entry to ACCESS, saturating.

## Timing
- Reset values: state IDLE; every output 0; `last=1`.
- An asynchronous reset assertion mid-transaction aborts it: no `m_ready_o` pulse, and `s_req_o` drops immediately.
- Request sampled in IDLE at cycle 0 → ACCESS in cycle 1.
  - Zero-wait slave (ready in cycle 1) → RESP and `m_ready_o` in cycle 2.
  - Each wait cycle adds 1 to that.
- Minimum 3 cycles per transaction; back-to-back throughput is one transaction per 3 cycles.
- `m_ready_o` is exactly one cycle wide and at most one bit is set.
- `s_req_o` has at most one bit set and is only non-zero in ACCESS.
- Timeout: with ready never asserted, RESP occurs TIMEOUT cycles after entering ACCESS.
- All outputs are registered except `s_req_o`, which is decoded from state and the latched slot.

## Structure
- `sys_bus_pkg` holds:
  - the `bus_state_e` enum (IDLE/ACCESS/RESP);
  - the `bus_cmd_t` struct (we, be, addr, wd);
  - the `SLOT_W = 8` constant.
- Sub-module `bus_rr_arbiter`: 2-way round-robin grant with the `last` register and a grant-enable input driven in IDLE.

## Test plan
- **Single read, zero-wait:** M0 reads `0x0000_0010`; slot 0 ready in the same cycle with rd=`0xDEADBEEF`. Required: `s_req_o=8'b0000_0001`, `s_addr_o=0x10`, `m_ready_o[0]` in cycle 2, `m_rd_o=0xDEADBEEF`, err=0.
- **Write to slot 7 with 2 wait states:** M1 writes be=`4'b0011`, wd=`0x1234_5678` to `0x0700_0004`. Required: `s_req_o[7]` high for 3 cycles, `s_addr_o=4`, `s_be_o=4'b0011`, `m_ready_o[1]` in cycle 4, err=0.
- **Contention:** both masters request continuously from reset. Required: grants alternate M0, M1, M0, M1 over 4 transactions, each 3 cycles apart.
- **Unmapped access:** M0 reads `0x0900_0000` with SLV_NUM=8. Required: `s_req_o` stays 0, `m_ready_o[0]` in cycle 2, err=1, rd=0.
- **Timeout:** slot 3 never readies. Required: err=1 on `m_ready_o` after 15 ACCESS cycles; the bus is free on the next cycle.
- **Reset mid-ACCESS:** drop `resetn_i` during a waiting slot-3 access. Required: `s_req_o` drops asynchronously, no `m_ready_o` pulse, and after release M0 wins the first tie.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared types for the system-bus arbiter.
// FSM states, the latched command bundle and the slot-field width.
package sys_bus_pkg;

  localparam int SLOT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } bus_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } bus_cmd_t;

endpackage

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: two-way round-robin grant.
// last points at the most recently granted master.
module bus_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt,
  output logic       gnt_vld
);

  logic last;

  assign gnt_vld = |req;

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (req == 2'b11): gnt = ~last;
      (req == 2'b10): gnt = 1'b1;
      default:        gnt = 1'b0;
    endcase
  end

  // Reset to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (en && gnt_vld) begin
      last <= gnt;
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: two-master system bus with slot decode,
// ready wait, read-data mux and unmapped/timeout errors.
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int SLV_NUM = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [1:0]            m_req_i,
  input  logic [1:0]            m_we_i,
  input  logic [7:0]            m_be_i,
  input  logic [63:0]           m_addr_i,
  input  logic [63:0]           m_wd_i,
  output logic [31:0]           m_rd_o,
  output logic [1:0]            m_ready_o,
  output logic                  m_err_o,
  output logic [SLV_NUM-1:0]    s_req_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_wd_o,
  input  logic [SLV_NUM*32-1:0] s_rd_i,
  input  logic [SLV_NUM-1:0]    s_ready_i
);

  localparam int IDX_W =
    (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  bus_state_e        state;
  bus_cmd_t          cmd;
  logic              gnt_q;
  logic              gnt;
  logic              gnt_vld;
  logic [CNT_W-1:0]  cnt;
  logic [SLOT_W-1:0] slot;
  logic [IDX_W-1:0]  slot_idx;
  logic              slot_ok;
  logic              hit;
  logic              tmo;
  logic [31:0]       rd_sel;

  assign slot     = cmd.addr[31:24];
  assign slot_idx = slot[IDX_W-1:0];
  assign slot_ok  =
    {1'b0, slot} < (SLOT_W + 1)'(SLV_NUM);
  assign hit      = slot_ok && s_ready_i[slot_idx];
  assign tmo      = cnt == CNT_W'(TIMEOUT - 1);
  assign rd_sel   = s_rd_i[{slot_idx, 5'd0} +: 32];

  assign s_we_o   = cmd.we;
  assign s_be_o   = cmd.be;
  assign s_wd_o   = cmd.wd;
  assign s_addr_o = {8'd0, cmd.addr[23:0]};

  // Decoded from state so an async reset drops it at once.
  always_comb begin
    s_req_o = '0;
    if (state == ACCESS && slot_ok) begin
      s_req_o[slot_idx] = 1'b1;
    end
  end

  bus_rr_arbiter u_arb (
    .clk     (clk_i),
    .rst_n   (resetn_i),
    .en      (state == IDLE),
    .req     (m_req_i),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= IDLE;
      cmd       <= '0;
      gnt_q     <= 1'b0;
      cnt       <= '0;
      m_ready_o <= '0;
      m_rd_o    <= '0;
      m_err_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            gnt_q <= gnt;
            cmd   <= '{
              we:   m_we_i[gnt],
              be:   m_be_i[{gnt, 2'b00} +: 4],
              addr: m_addr_i[{gnt, 5'd0} +: 32],
              wd:   m_wd_i[{gnt, 5'd0} +: 32]
            };
            cnt   <= '0;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!slot_ok || hit || tmo) begin
            state     <= RESP;
            m_ready_o <= {gnt_q, ~gnt_q};
            m_err_o   <= ~hit;
            m_rd_o    <= (hit && !cmd.we) ? rd_sel : '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          m_ready_o <= '0;
          m_rd_o    <= '0;
          m_err_o   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: directed cases plus random traffic
// checked against a transaction-level bus model.
module tb_sys_bus_arbiter;

  localparam int SLV = 8;
  localparam int TMO = 15;

  logic             clk = 1'b0;
  logic             resetn_i;
  logic [1:0]       m_req_i;
  logic [1:0]       m_we_i;
  logic [7:0]       m_be_i;
  logic [63:0]      m_addr_i;
  logic [63:0]      m_wd_i;
  logic [31:0]      m_rd_o;
  logic [1:0]       m_ready_o;
  logic             m_err_o;
  logic [SLV-1:0]   s_req_o;
  logic             s_we_o;
  logic [3:0]       s_be_o;
  logic [31:0]      s_addr_o;
  logic [31:0]      s_wd_o;
  logic [SLV*32-1:0] s_rd_i;
  logic [SLV-1:0]   s_ready_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sys_bus_arbiter #(.SLV_NUM(SLV), .TIMEOUT(TMO)) dut (
    .clk_i     (clk),
    .resetn_i  (resetn_i),
    .m_req_i   (m_req_i),
    .m_we_i    (m_we_i),
    .m_be_i    (m_be_i),
    .m_addr_i  (m_addr_i),
    .m_wd_i    (m_wd_i),
    .m_rd_o    (m_rd_o),
    .m_ready_o (m_ready_o),
    .m_err_o   (m_err_o),
    .s_req_o   (s_req_o),
    .s_we_o    (s_we_o),
    .s_be_o    (s_be_o),
    .s_addr_o  (s_addr_o),
    .s_wd_o    (s_wd_o),
    .s_rd_i    (s_rd_i),
    .s_ready_i (s_ready_i)
  );

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic drive_m(input int m, input bit req,
                         input bit we,
                         input logic [3:0] be,
                         input logic [31:0] a,
                         input logic [31:0] wd);
    m_req_i[m]          = req;
    m_we_i[m]           = we;
    m_be_i[m*4 +: 4]    = be;
    m_addr_i[m*32 +: 32] = a;
    m_wd_i[m*32 +: 32]  = wd;
  endtask

  task automatic do_reset();
    resetn_i  = 1'b0;
    m_req_i   = '0;
    m_we_i    = '0;
    m_be_i    = '0;
    m_addr_i  = '0;
    m_wd_i    = '0;
    s_rd_i    = '0;
    s_ready_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", m_ready_o, 0);
    chk("rst_sreq", s_req_o, 0);
    chk("rst_rd", {m_err_o, m_rd_o}, 0);
    chk("rst_addr", s_addr_o, 0);
    chk("rst_cmd", {s_we_o, s_be_o, s_wd_o}, 0);
    resetn_i = 1'b1;
  endtask

  // Cycle 0 is the IDLE cycle in which the request is driven.
  task automatic txn(input string nm, input int m,
                     input bit we, input logic [3:0] be,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input int rslot, input int rdly,
                     input logic [31:0] rdv,
                     input logic [7:0] noise,
                     input logic [7:0] e_sreq,
                     input int e_scyc, input int e_cyc,
                     input bit e_err,
                     input logic [31:0] e_rd);
    int n = 0;
    int got = -1;
    int scyc = 0;
    logic [7:0] mask;
    mask = (rslot >= 0) ? 8'(1 << rslot) : 8'h0;
    drive_m(m, 1'b1, we, be, a, wd);
    s_ready_i = noise & ~mask;
    if (rslot >= 0) s_rd_i[rslot*32 +: 32] = rdv;
    while (got < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (s_req_o != 0) begin
        scyc++;
        if (scyc == 1) begin
          chk({nm, "_sreq"}, s_req_o, e_sreq);
          chk({nm, "_saddr"}, s_addr_o,
              {8'd0, a[23:0]});
          chk({nm, "_scmd"}, {s_we_o, s_be_o, s_wd_o},
              {we, be, wd});
        end
      end
      if (m_ready_o != 0) begin
        got = n;
        chk({nm, "_rdy"}, m_ready_o, 2'b01 << m);
        chk({nm, "_err"}, m_err_o, e_err);
        chk({nm, "_rd"}, m_rd_o, e_rd);
      end
      if (rslot >= 0 && rdly >= 0 && n - 1 >= rdly)
        s_ready_i[rslot] = 1'b1;
    end
    chk({nm, "_cyc"}, got, e_cyc);
    chk({nm, "_scyc"}, scyc, e_scyc);
    drive_m(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    s_ready_i = '0;
    @(negedge clk);
    chk({nm, "_pulse"}, m_ready_o, 0);
  endtask

  // Random-traffic master state and bus model.
  bit          pend [2];
  bit          cwe  [2];
  logic [3:0]  cbe  [2];
  logic [31:0] cad  [2];
  logic [31:0] cwd  [2];
  bit          last;
  bit          t_v;
  int          t_m, t_start, t_cap, t_resp, t_slot;
  int          free_at;
  bit          t_map, t_err, t_we;
  logic [3:0]  t_be;
  logic [31:0] t_addr, t_wd, t_rd;
  logic [7:0]  exp_req;
  logic [1:0]  exp_rdy;
  int          pulses [$];
  int          exp_p [4] = '{9, 22, 33, 46};

  task automatic new_cmd(input int m);
    int slot;
    slot = $urandom_range(0, 7);
    if (slot == 3 && $urandom_range(0, 3) != 0) slot = 5;
    if ($urandom_range(0, 9) == 0)
      slot = $urandom_range(8, 255);
    cwe[m] = 1'($urandom_range(0, 1));
    cbe[m] = 4'($urandom);
    cad[m] = {8'(slot), 24'($urandom)};
    cwd[m] = $urandom;
    pend[m] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    txn("rd0", 0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,
        0, 0, 32'hDEAD_BEEF, 8'h00,
        8'h01, 1, 2, 1'b0, 32'hDEAD_BEEF);
    txn("wr7", 1, 1'b1, 4'b0011, 32'h0700_0004,
        32'h1234_5678, 7, 2, 32'hFFFF_FFFF, 8'h7F,
        8'h80, 3, 4, 1'b0, 32'h0);
    txn("unmap", 0, 1'b0, 4'hF, 32'h0900_0000, 32'h0,
        -1, -1, 32'h0, 8'hFF,
        8'h00, 0, 2, 1'b1, 32'h0);
    txn("tmo", 0, 1'b0, 4'hF, 32'h0300_0000, 32'h0,
        3, -1, 32'h5555_5555, 8'hF7,
        8'h08, 15, 16, 1'b1, 32'h0);
    txn("free", 1, 1'b0, 4'hF, 32'h0100_0020, 32'h0,
        1, 0, 32'hCAFE_F00D, 8'h00,
        8'h02, 1, 2, 1'b0, 32'hCAFE_F00D);

    // Contention from reset: encode pulse as cycle*4+ready.
    do_reset();
    drive_m(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    drive_m(1, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
    s_ready_i = 8'h01;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (m_ready_o != 0)
        pulses.push_back(n * 4 + int'(m_ready_o));
    end
    chk("cont_n", pulses.size(), 4);
    for (int i = 0; i < pulses.size() && i < 4; i++)
      chk("cont_gnt", pulses[i], exp_p[i]);

    // Async reset in the middle of a waiting slot-3 access.
    do_reset();
    drive_m(0, 1'b1, 1'b0, 4'hF, 32'h0300_0000, 32'h0);
    repeat (4) @(negedge clk);
    chk("rma_sreq", s_req_o, 8'h08);
    #2 resetn_i = 1'b0;
    #1 chk("rma_async", s_req_o, 0);
    drive_m(1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    begin
      int pul = 0;
      repeat (3) begin
        @(posedge clk);
        #1 if (m_ready_o != 0) pul++;
      end
      chk("rma_nopulse", pul, 0);
    end
    @(negedge clk);
    resetn_i = 1'b1;
    drive_m(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    s_ready_i = 8'h01;
    begin
      int n = 0;
      while (m_ready_o == 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("rma_first", m_ready_o, 2'b01);
      chk("rma_cyc", n, 2);
    end

    // Random traffic against the transaction model.
    do_reset();
    last    = 1'b1;
    t_v     = 1'b0;
    free_at = 0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      exp_req = '0;
      exp_rdy = '0;
      if (t_v && t_map && cyc > t_start && cyc <= t_cap)
        exp_req = 8'(1 << t_slot);
      if (t_v && cyc == t_resp)
        exp_rdy = 2'(1 << t_m);
      chk("r_sreq", s_req_o, exp_req);
      chk("r_rdy", m_ready_o, exp_rdy);
      if (exp_rdy != 0) begin
        chk("r_err", m_err_o, t_err);
        chk("r_rd", m_rd_o, t_rd);
        pend[t_m] = 1'b0;
      end
      if (t_v && cyc > t_start && cyc < t_resp) begin
        chk("r_saddr", s_addr_o, {8'd0, t_addr[23:0]});
        chk("r_scmd", {s_we_o, s_be_o, s_wd_o},
            {t_we, t_be, t_wd});
      end

      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) == 0)
          new_cmd(m);
        if (!pend[m]) begin
          cad[m] = $urandom;
          cwd[m] = $urandom;
        end
        drive_m(m, pend[m], cwe[m], cbe[m],
                cad[m], cwd[m]);
      end
      for (int k = 0; k < SLV; k++)
        s_rd_i[k*32 +: 32] = $urandom;

      if (cyc >= free_at && m_req_i != 0) begin
        t_m     = (m_req_i == 2'b11) ? int'(!last)
                                     : int'(m_req_i[1]);
        last    = t_m[0];
        t_v     = 1'b1;
        t_start = cyc;
        t_we    = cwe[t_m];
        t_be    = cbe[t_m];
        t_addr  = cad[t_m];
        t_wd    = cwd[t_m];
        t_slot  = int'(t_addr[31:24]);
        t_map   = t_slot < SLV;
        t_rd    = '0;
        if (!t_map) begin
          t_cap = cyc + 1;
          t_err = 1'b1;
        end else if (t_slot == 3) begin
          t_cap = cyc + TMO;
          t_err = 1'b1;
        end else begin
          t_cap = cyc + 1 + $urandom_range(0, 7);
          t_err = 1'b0;
        end
        t_resp  = t_cap + 1;
        free_at = t_resp + 1;
      end

      s_ready_i = 8'($urandom);
      if (t_v && t_map && cyc > t_start && cyc <= t_cap) begin
        s_ready_i[t_slot] = (cyc == t_cap) && !t_err;
        if (cyc == t_cap && !t_err && !t_we)
          t_rd = s_rd_i[t_slot*32 +: 32];
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
